// File: rtl/demux1to8_deser_pkg.sv
// Shared constants and FSM state type for the 1-to-8 demux/deserializer.
//   LANES   : number of output lanes per frame
//   SEL_W   : width of a lane index
//   state_e : FILL (collecting lanes) / HOLD (frame presented downstream)
package demux_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : demux_pkg

// File: rtl/demux1to8_deser_if.sv
// Bus bundle for demux1to8_deser: serial item input handshake plus the
// parallel frame output handshake.
//   master : item producer / frame consumer (drives in_*, auto_sel, out_ready)
//   slave  : the deserializer (drives in_ready, out_*, lane_mask, overwrite_err)
interface demux1to8_deser_if #(
  parameter int unsigned WIDTH = 1
);
  import demux_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   auto_sel;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       lane_mask;
  logic                   overwrite_err;

  modport master (
    output in_valid, in_data, in_sel, auto_sel, out_ready,
    input  in_ready, out_data, out_valid, lane_mask, overwrite_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, auto_sel, out_ready,
    output in_ready, out_data, out_valid, lane_mask, overwrite_err
  );

endinterface : demux1to8_deser_if

// File: rtl/demux1to8_deser_lane_bank.sv
// Lane storage: 3-to-8 write decoder, LANES x WIDTH data registers and the
// per-lane written mask.
//   clk, rst   : clock, synchronous active-high reset
//   we_i       : write the addressed lane this cycle
//   lane_i     : lane index to write
//   data_i     : lane payload
//   clr_i      : clear the written mask (frame handed off); data is kept
//   data_o     : all lanes, lane i at [i*WIDTH +: WIDTH]
//   mask_o     : lanes written in the current frame
//   hit_c_o    : addressed lane is already written (combinational)
//   full_c_o   : mask would be all ones after writing the addressed lane
module demux_lane_bank
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [SEL_W-1:0]       lane_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   clr_i,
  output logic [LANES*WIDTH-1:0] data_o,
  output logic [LANES-1:0]       mask_o,
  output logic                   hit_c_o,
  output logic                   full_c_o
);

  logic [LANES*WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [LANES-1:0]       lane_onehot_c;

  assign lane_onehot_c = LANES'(1) << lane_i;
  assign hit_c_o       = mask_q[lane_i];
  assign full_c_o      = &(mask_q | lane_onehot_c);

  // Decoded write into the addressed lane; clear takes priority over write
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (clr_i) begin
      mask_d = '0;
    end else if (we_i) begin
      mask_d = mask_q | lane_onehot_c;
    end
    for (int i = 0; i < int'(LANES); i++) begin
      if (we_i && lane_onehot_c[i]) begin
        data_d[i*WIDTH +: WIDTH] = data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      mask_q <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign data_o = data_q;
  assign mask_o = mask_q;

endmodule : demux_lane_bank

// File: rtl/demux1to8_deser.sv
// Registered 1-to-8 demultiplexer / deserializer. Items are steered into one
// of eight lanes (explicit in_sel or an auto-incrementing lane counter); once
// every lane has been written the frame is held on out_data until taken.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of demux1to8_deser_if (item input, frame output,
//              lane_mask and one-cycle overwrite_err pulse)
module demux1to8_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  demux1to8_deser_if.slave bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             in_ready_c;
  logic             we_c;
  logic             clr_c;
  logic [SEL_W-1:0] lane_c;
  logic             hit_c;
  logic             full_c;

  assign lane_c = bus.auto_sel ? cnt_q : bus.in_sel;

  demux_lane_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_c),
    .lane_i   (lane_c),
    .data_i   (bus.in_data),
    .clr_i    (clr_c),
    .data_o   (bus.out_data),
    .mask_o   (bus.lane_mask),
    .hit_c_o  (hit_c),
    .full_c_o (full_c)
  );

  // Next-state, lane counter and handshake decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    we_c       = 1'b0;
    clr_c      = 1'b0;
    in_ready_c = (state_q == FILL) && !rst;
    case (state_q)
      FILL: begin
        if (bus.in_valid && in_ready_c) begin
          we_c  = 1'b1;
          err_d = hit_c;
          // Counter only advances on auto-mode accepts
          if (bus.auto_sel) begin
            cnt_d = cnt_q + SEL_W'(1);
          end
          if (full_c) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          clr_c   = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = (state_q == HOLD);
  assign bus.overwrite_err = err_q;

endmodule : demux1to8_deser

// File: tb/tb_demux1to8_deser.sv
// Scoreboard bench for demux1to8_deser: directed scenarios followed by random
// traffic, checked against a lane-array reference model.
module tb_demux1to8_deser;

  localparam int unsigned W = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux1to8_deser_if #(.WIDTH(W)) bus ();

  demux1to8_deser #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lane contents, written flags, auto lane pointer, holding flag
  logic     m_lanes [8];
  bit       m_mask  [8];
  int       m_cnt   = 0;
  bit       m_hold  = 1'b0;
  bit       m_err   = 1'b0;
  bit       m_known = 1'b0;
  logic [7:0] sb_q [$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] m_data();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_lanes[i];
    return v;
  endfunction

  function automatic logic [7:0] m_maskv();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_mask[i];
    return v;
  endfunction

  // One cycle: check registered outputs, drive inputs, check in_ready, advance model
  task automatic step(input logic r, input logic v, input logic d,
                      input logic [2:0] s, input logic a, input logic ordy);
    int  lane;
    bit  all;
    @(negedge clk);
    if (m_known) begin
      check("out_data",      64'(bus.out_data),      64'(m_data()));
      check("lane_mask",     64'(bus.lane_mask),     64'(m_maskv()));
      check("out_valid",     64'(bus.out_valid),     64'(m_hold));
      check("overwrite_err", 64'(bus.overwrite_err), 64'(m_err));
    end
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sel    = s;
    bus.auto_sel  = a;
    bus.out_ready = ordy;
    #1;
    if (m_known || r) check("in_ready", 64'(bus.in_ready), 64'(!r && !m_hold));
    if (r) begin
      if (m_hold && sb_q.size() > 0) void'(sb_q.pop_back());
      for (int i = 0; i < 8; i++) begin
        m_lanes[i] = 1'b0;
        m_mask[i]  = 1'b0;
      end
      m_cnt   = 0;
      m_hold  = 1'b0;
      m_err   = 1'b0;
      m_known = 1'b1;
    end else begin
      m_err = 1'b0;
      if (!m_hold && v) begin
        lane = a ? m_cnt : int'(s);
        if (m_mask[lane]) m_err = 1'b1;
        m_lanes[lane] = d;
        m_mask[lane]  = 1'b1;
        if (a) m_cnt = (m_cnt + 1) % 8;
        all = 1'b1;
        for (int i = 0; i < 8; i++) if (!m_mask[i]) all = 1'b0;
        if (all) begin
          m_hold = 1'b1;
          sb_q.push_back(m_data());
        end
      end else if (m_hold && ordy) begin
        m_hold = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < 8; i++) m_mask[i] = 1'b0;
      end
    end
  endtask

  // Monitor: compare each handed-off frame with the oldest expected frame
  always @(posedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame: got %0h expected none (scoreboard empty) at %0t", bus.out_data, $time);
      end else begin
        check("frame", 64'(bus.out_data), 64'(sb_q.pop_front()));
      end
    end
  end

  logic [7:0] auto_bits;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.auto_sel  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted
    step(1, 1, 1, 3'd0, 1, 1);
    step(1, 1, 1, 3'd0, 1, 1);

    // Auto mode: bits 1,0,1,1,0,0,1,0 into lanes 0..7
    auto_bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) step(0, 1, auto_bits[i], 3'd0, 1, 1);
    @(posedge clk); #1;
    check("auto_frame_data",  64'(bus.out_data),  64'(8'h4D));
    check("auto_frame_valid", 64'(bus.out_valid), 64'(1));
    check("auto_hold_ready",  64'(bus.in_ready),  64'(0));
    step(0, 0, 0, 3'd0, 1, 1);
    step(0, 0, 0, 3'd0, 1, 1);

    // Explicit mode, descending select, consumer stalls 5 cycles
    for (int s = 7; s >= 0; s--) step(0, 1, 1'(s), 3'(s), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1'($urandom), 3'($urandom), 0, 0);
    @(posedge clk); #1;
    check("expl_frame_data",  64'(bus.out_data),  64'(8'hAA));
    check("expl_frame_valid", 64'(bus.out_valid), 64'(1));
    check("expl_hold_ready",  64'(bus.in_ready),  64'(0));
    step(0, 0, 0, 3'd0, 0, 1);
    step(0, 0, 0, 3'd0, 0, 0);

    // Overwrite: lane 3 written twice
    step(0, 1, 0, 3'd3, 0, 0);
    step(0, 1, 1, 3'd3, 0, 0);
    @(posedge clk); #1;
    check("ovw_err",   64'(bus.overwrite_err), 64'(1));
    check("ovw_mask",  64'(bus.lane_mask),     64'(8'h08));
    check("ovw_lane3", 64'(bus.out_data[3]),   64'(1));
    check("ovw_valid", 64'(bus.out_valid),     64'(0));
    step(0, 0, 0, 3'd0, 0, 0);
    for (int s = 0; s < 8; s++) if (s != 3) step(0, 1, 1'($urandom), 3'(s), 0, 0);
    step(0, 0, 0, 3'd0, 0, 1);
    step(0, 0, 0, 3'd0, 0, 0);

    // Mixed mode: auto 0-3, explicit 4-6, auto collides on lane 4, explicit 7
    for (int i = 0; i < 4; i++) step(0, 1, 1'($urandom), 3'd0, 1, 0);
    for (int s = 4; s < 7; s++) step(0, 1, 1'($urandom), 3'(s), 0, 0);
    step(0, 1, 1, 3'd0, 1, 0);
    @(posedge clk); #1;
    check("mix_err",  64'(bus.overwrite_err), 64'(1));
    check("mix_mask", 64'(bus.lane_mask),     64'(8'h7F));
    step(0, 1, 0, 3'd7, 0, 0);
    step(0, 0, 0, 3'd0, 0, 1);
    step(0, 0, 0, 3'd0, 0, 0);

    // Reset mid-frame after 5 auto accepts
    for (int i = 0; i < 5; i++) step(0, 1, 1, 3'd0, 1, 1);
    step(1, 1, 1, 3'd0, 1, 1);
    @(posedge clk); #1;
    check("midrst_mask",  64'(bus.lane_mask), 64'(0));
    check("midrst_valid", 64'(bus.out_valid), 64'(0));
    for (int i = 0; i < 8; i++) step(0, 1, 1'(i == 0), 3'd5, 1, 1);
    step(0, 0, 0, 3'd0, 1, 1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    end

    // Drain and confirm every expected frame was delivered
    for (int i = 0; i < 4; i++) step(0, 0, 0, 3'd0, 0, 1);
    step(0, 0, 0, 3'd0, 0, 0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_demux1to8_deser

// File: doc/demux1to8_deser.md
# demux1to8_deser

Registered 1-to-8 demultiplexer / deserializer: the receive-side counterpart of the team's 8:1 mux. Accepts one WIDTH-bit item per handshake, steers it into one of eight lane registers (by explicit select or an internal auto-incrementing lane counter), and presents the assembled 8-lane frame on a valid/ready output port. Sits after a serialized link and before any consumer that expects the parallel `in` bus the mux consumes.

## Interface
- WIDTH, 1, bits per lane
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input item present
- in_ready  out  1  block can accept an item
- in_data  in  WIDTH  item payload
- in_sel  in  3  target lane when auto_sel=0
- auto_sel  in  1  1: lane taken from internal counter, in_sel ignored
- out_data  out  8*WIDTH  lane i at [i*WIDTH +: WIDTH]
- out_valid  out  1  complete frame held
- out_ready  in  1  consumer takes frame
- lane_mask  out  8  lanes written in current frame
- overwrite_err  out  1  one-cycle pulse: accepted write hit an already-written lane

## Operation
- States: FILL, HOLD.
- FILL: in_ready=1. Accept = in_valid && in_ready. On accept: lane L = auto_sel ? lane_cnt : in_sel; out_data lane L <= in_data; lane_mask[L] <= 1; if auto_sel, lane_cnt <= lane_cnt+1 (3-bit, wraps 7->0).
- Accept to a lane whose mask bit is already 1: data overwritten, mask unchanged, overwrite_err=1 next cycle. Applies in both modes (mixed-mode frames can collide).
- When an accept makes lane_mask 8'hFF: next state HOLD.
- HOLD: in_ready=0, out_valid=1, out_data stable. On out_valid && out_ready: lane_mask <= 0, lane_cnt <= 0, state <= FILL.
- out_data is not cleared on handoff; lanes keep old values until rewritten.
- auto_sel may change between accepts; lane_cnt neither resets nor advances on explicit-mode accepts.

## Timing
- Reset (rst high at an edge): state FILL, lane_cnt 0, lane_mask 0, out_data 0, out_valid 0, overwrite_err 0. in_ready=0 while rst is high; 1 the cycle after.
- rst overrides everything; reset mid-frame or during HOLD discards the frame, no out_valid.
- in_ready = (state==FILL) && !rst, combinational from state; no dependence on out_ready.
- Write latency: lane visible on out_data and lane_mask one cycle after the accept edge.
- Frame latency: out_valid rises the cycle after the completing accept; minimum 8 accepts, 8 cycles, first-accept edge to out_valid.
- Handoff edge: no input accepted in the same cycle (in_ready=0); in_ready=1 the following cycle. Back-to-back frames: 8 accept cycles + 1 HOLD cycle minimum = 9 cycles/frame.
- out_ready while out_valid=0 is ignored.

## Structure
- Package demux_pkg: LANES=8, SEL_W=3, state enum {FILL, HOLD}.
- Sub-module demux_lane_bank: 3-to-8 write decoder plus 8×WIDTH lane registers and lane_mask, with write-enable, lane index, data, clear-mask inputs. Top holds FSM, lane_cnt, handshakes, error pulse.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> all outputs 0, in_ready=0, no write; in_ready=1 first cycle after.
- Auto mode, WIDTH=1, bits 1,0,1,1,0,0,1,0 to lanes 0..7, out_ready=1 -> out_data=8'h4D, out_valid one cycle after 8th accept, in_ready back 1 cycle later.
- Explicit mode, write sel 7..0 descending with data=sel, out_ready=0 for 5 cycles -> out_valid held, out_data=8'hAA stable, in_ready=0, extra in_valid ignored.
- Overwrite: explicit sel=3 twice (data 0 then 1) -> overwrite_err pulses once, lane_mask=8'h08, lane 3=1, frame still needs 7 more lanes.
- Mixed: auto writes lanes 0-3, explicit sel=4..6, auto again -> lane_cnt=4 hits lane 4, overwrite_err=1; then explicit sel=7 completes frame.
- Reset mid-frame after 5 auto accepts -> lane_mask=0, lane_cnt=0; next 8 auto accepts produce one frame with lane 0 first.
